mdu_iter: RTL and testbench

//  Iterative RV M-extension multiply/divide unit; the consumer of the op0/op1 operand pair driven by the EX operand selector.

---
 rtl/mdu_iter_pkg.sv | 28 ++
 rtl/mdu_abs_neg.sv | 12 +
 rtl/mdu_iter.sv | 166 ++++++++++++++++
 tb/tb_mdu_iter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 op encodings, FSM states
// and the default datapath width (64 bits when RV64 is defined).
package mdu_iter_pkg;

`ifdef RV64
  localparam int unsigned XlenDefault = 64;
`else
  localparam int unsigned XlenDefault = 32;
`endif

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module mdu_abs_neg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit, one bit per cycle over XLEN cycles.
// Divider hardware is present only when MDU_DIV_EN is defined.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned XLEN  = XlenDefault,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op0,
  input  logic [XLEN-1:0] op1,
  input  logic [2:0]      mdu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  mdu_state_e       state;
  mdu_op_e          op_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc, lo, opnd;
  logic             neg_res;

  mdu_op_e          op_in;
  logic             is_div_in, sign0, sign1, special;
  logic [XLEN-1:0]  mag0, mag1, special_res;
  logic [XLEN:0]    mul_sum;
  logic [XLEN-1:0]  acc_nxt, lo_nxt, mul_res, calc_res;
  logic [2*XLEN-1:0] prod_fix;

  assign op_in     = mdu_op_e'(mdu_op);
  assign is_div_in = mdu_op[2];
  assign sign0     = (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem}) & op0[XLEN-1];
  assign sign1     = (op_in inside {OpMulh, OpDiv, OpRem}) & op1[XLEN-1];

  mdu_abs_neg #(.W(XLEN)) u_abs0 (.a(op0), .neg(sign0), .y(mag0));
  mdu_abs_neg #(.W(XLEN)) u_abs1 (.a(op1), .neg(sign1), .y(mag1));

`ifdef MDU_DIV_EN
  logic            neg_rem, div_zero, div_ovf;
  logic [XLEN:0]   div_sh, div_diff;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign div_zero = (op1 == '0);
  assign div_ovf  = (op_in inside {OpDiv, OpRem}) && (op0 == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (op1 == '1);
  assign special  = is_div_in & (div_zero | div_ovf);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = mdu_op[1] ? op0 : '1;
    else          special_res = mdu_op[1] ? '0 : op0;
  end

  mdu_abs_neg #(.W(XLEN)) u_fix_quo (.a(lo_nxt), .neg(neg_res), .y(quo_fix));
  mdu_abs_neg #(.W(XLEN)) u_fix_rem (.a(acc_nxt), .neg(neg_rem), .y(rem_fix));
`else
  // Without a divider every div/rem encoding completes immediately with zero.
  assign special     = is_div_in;
  assign special_res = '0;
`endif

  // One iteration: multiply shifts {acc,lo} right after adding opnd; divide shifts the
  // dividend out of lo into acc and shifts quotient bits back into lo.
  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    acc_nxt = mul_sum[XLEN:1];
    lo_nxt  = {mul_sum[0], lo[XLEN-1:1]};
`ifdef MDU_DIV_EN
    div_sh   = {acc, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        acc_nxt = div_diff[XLEN-1:0];
        lo_nxt  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = div_sh[XLEN-1:0];
        lo_nxt  = {lo[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

  mdu_abs_neg #(.W(2*XLEN)) u_fix_prod (.a({acc_nxt, lo_nxt}), .neg(neg_res), .y(prod_fix));

  always_comb begin
    mul_res  = (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    calc_res = mul_res;
`ifdef MDU_DIV_EN
    if (op_q[2]) calc_res = op_q[1] ? rem_fix : quo_fix;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      op_q      <= OpMul;
      acc       <= '0;
      lo        <= '0;
      opnd      <= '0;
      neg_res   <= 1'b0;
`ifdef MDU_DIV_EN
      neg_rem   <= 1'b0;
`endif
    end else if (flush) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            op_q     <= op_in;
            cnt      <= '0;
            neg_res  <= sign0 ^ sign1;
`ifdef MDU_DIV_EN
            neg_rem  <= sign0;
`endif
            in_ready <= 1'b0;
            if (special) begin
              state     <= StDone;
              out_valid <= 1'b1;
              result    <= special_res;
            end else begin
              state <= StCalc;
              acc   <= '0;
              lo    <= is_div_in ? mag0 : mag1;
              opnd  <= is_div_in ? mag1 : mag0;
            end
          end
        end
        StCalc: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) begin
            state     <= StDone;
            out_valid <= 1'b1;
            result    <= calc_res;
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (XLEN=32); div expectations follow MDU_DIV_EN.
module tb_mdu_iter;

`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  localparam int DivLat = DivEn ? 33 : 1;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op0, op1, result;
  logic [2:0]  mdu_op;

  int n_assert = 0;
  int n_fail   = 0;

  mdu_iter #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op0      (op0),
    .op1      (op1),
    .mdu_op   (mdu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one op, wait for out_valid (bounded), optionally hold out_ready low, then handshake.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int          lat;
    logic        busy_ok, stable_ok;
    logic [31:0] r0;
    op0 = a; op1 = b; mdu_op = op; in_valid = 1'b1;
    check({tag, " idle_before"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      step();
      lat++;
    end
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp));
    check({tag, " ready_in_done"}, 64'(in_ready), 64'd0);
    if (hold > 0) begin
      r0 = result;
      stable_ok = 1'b1;
      repeat (hold) begin
        step();
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r0) stable_ok = 1'b0;
      end
      check({tag, " stable"}, 64'(stable_ok), 64'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " back_idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    logic quiet;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op0 = '0; op1 = '0; mdu_op = '0;
    #1;
    check("reset_outputs", {31'd0, in_ready, out_valid, result}, {31'd0, 1'b1, 1'b0, 32'd0});
    step();
    step();
    rst = 1'b0;
    check("post_reset", {31'd0, in_ready, out_valid, result}, {31'd0, 1'b1, 1'b0, 32'd0});

    run_op("mul_7x6",       3'b000, 32'd7,        32'd6,        32'h0000002A, 33, 0);
    run_op("mul_neg",       3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33, 0);
    run_op("mulh_minmin",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run_op("mulhu_max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("mulhsu_m1x2",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);

    run_op("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2, DivEn ? 32'hFFFFFFFD : 32'd0, DivLat, 0);
    run_op("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2, DivEn ? 32'hFFFFFFFF : 32'd0, DivLat, 0);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, DivEn ? 32'd14 : 32'd0, DivLat, 0);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, DivEn ? 32'd2 : 32'd0, DivLat, 0);
    run_op("divu_by0", 3'b101, 32'd5, 32'd0, DivEn ? 32'hFFFFFFFF : 32'd0, 1, 0);
    run_op("rem_by0",  3'b110, 32'd5, 32'd0, DivEn ? 32'd5 : 32'd0, 1, 0);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, DivEn ? 32'h80000000 : 32'd0, 1, 0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0);

    // Backpressure, then an immediate accept right after the handshake.
    run_op("mul_hold", 3'b000, 32'd3, 32'd5, 32'd15, 33, 10);
    run_op("mulhu_next", 3'b011, 32'h12345678, 32'h10, 32'h00000001, 33, 0);

    // Flush during calculation at T+5.
    op0 = 32'd9; op1 = 32'd9; mdu_op = 3'b000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", {in_ready, out_valid}, 2'b10);
    quiet = 1'b1;
    repeat (40) begin
      step();
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    check("flush_no_result", 64'(quiet), 64'd1);

    // Flush with in_valid in IDLE must not accept.
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {in_ready, out_valid}, 2'b10);
    quiet = 1'b1;
    repeat (40) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    check("flush_accept_quiet", 64'(quiet), 64'd1);

    // Async reset at T+10: outputs return to reset values without a clock edge.
    op0 = 32'd11; op1 = 32'd13; mdu_op = 3'b000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    #1;
    check("rst_midcalc", {31'd0, in_ready, out_valid, result}, {31'd0, 1'b1, 1'b0, 32'd0});
    step();
    rst = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    check("rst_no_result", 64'(quiet), 64'd1);

    run_op("mul_after_rst", 3'b000, 32'd11, 32'd13, 32'd143, 33, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
